// File: rtl/if_fetch_unit_pkg.sv
// Shared widths, reset address and the {pc, inst} buffer entry layout for the
// instruction-fetch front end.
package if_fetch_unit_pkg;

    localparam int WORD    = 32;
    localparam int INST_W  = 32;
    localparam int ENTRY_W = WORD + INST_W;

    localparam logic [WORD-1:0] RESET_PC_DEFAULT = 32'h1C00_0000;

    typedef struct packed {
        logic [WORD-1:0]   pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    function automatic logic [WORD-1:0] word_align(input logic [WORD-1:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/inst_fifo.sv
// Synchronous FIFO of {pc, inst} entries with a synchronous flush and a
// registered head, so a push becomes visible on the output one cycle later.
module inst_fifo
    import if_fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic [ENTRY_W-1:0]     push_data,
    input  logic                   pop,
    output logic                   head_valid,
    output logic [ENTRY_W-1:0]     head_data,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] PTR_ONE = 1;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [PW-1:0]      rd_ptr_next;
    logic [PW:0]        push_ext;
    logic [PW:0]        pop_ext;
    logic [PW:0]        remain;
    logic [PW:0]        count_next;
    logic               do_pop;

    assign do_pop      = pop && head_valid;
    assign push_ext    = {{PW{1'b0}}, push};
    assign pop_ext     = {{PW{1'b0}}, do_pop};
    assign remain      = count - pop_ext;
    assign count_next  = remain + push_ext;
    assign rd_ptr_next = do_pop ? rd_ptr + PTR_ONE : rd_ptr;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // When no older entry survives this cycle, the new head is the word being pushed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            head_valid <= 1'b0;
            head_data  <= '0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            head_valid <= 1'b0;
            head_data  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            rd_ptr     <= rd_ptr_next;
            count      <= count_next;
            head_valid <= (count_next != '0);
            if (count_next == '0) begin
                head_data <= '0;
            end else if (remain == '0) begin
                head_data <= push_data;
            end else begin
                head_data <= mem[rd_ptr_next];
            end
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Fetch front end: owns the fetch PC, issues credit-limited in-order requests,
// buffers responses for decode and squashes wrong-path fetches on redirect.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst_pc,
    output logic [31:0] inst,
    input  logic        inst_ready
);

    localparam int CW = $clog2(BUF_DEPTH) + 1;
    localparam logic [CW-1:0] ONE       = 1;
    localparam logic [CW:0]   DEPTH_LIM = BUF_DEPTH[CW:0];

    logic [WORD-1:0]    fetch_pc;
    logic [WORD-1:0]    resp_pc;
    logic [CW-1:0]      outstanding;
    logic [CW-1:0]      outstanding_next;
    logic [CW-1:0]      discard;
    logic [CW-1:0]      fifo_count;
    logic [CW:0]        credit_used;
    logic               grant;
    logic               take_rsp;
    fetch_entry_t       push_entry;
    fetch_entry_t       head_entry;
    logic [ENTRY_W-1:0] head_bits;

    // Handshakes: a request transfers when imem_req && imem_gnt, an instruction
    // leaves the buffer when inst_valid && inst_ready; the valid side holds its
    // payload stable until the transfer, and imem_rvalid is never backpressured.
    assign credit_used = {1'b0, outstanding} + {1'b0, fifo_count};
    assign imem_req    = !rst && (credit_used < DEPTH_LIM);
    assign imem_addr   = fetch_pc;
    assign grant       = imem_req && imem_gnt;
    assign take_rsp    = imem_rvalid && !redirect_valid && (discard == '0);

    always_comb begin
        outstanding_next = outstanding;
        if (grant && !imem_rvalid) begin
            outstanding_next = outstanding + ONE;
        end else if (!grant && imem_rvalid) begin
            outstanding_next = outstanding - ONE;
        end
    end

    // On redirect every request still unanswered after this cycle is wrong-path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (redirect_valid) begin
                fetch_pc <= word_align(redirect_pc);
                resp_pc  <= word_align(redirect_pc);
                discard  <= outstanding_next;
            end else begin
                if (grant) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (take_rsp) begin
                    resp_pc <= resp_pc + 32'd4;
                end
                if (imem_rvalid && (discard != '0)) begin
                    discard <= discard - ONE;
                end
            end
        end
    end

    assign push_entry.pc   = resp_pc;
    assign push_entry.inst = imem_rdata;

    inst_fifo #(
        .DEPTH (BUF_DEPTH)
    ) u_inst_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect_valid),
        .push       (take_rsp),
        .push_data  (push_entry),
        .pop        (inst_ready),
        .head_valid (inst_valid),
        .head_data  (head_bits),
        .count      (fifo_count)
    );

    assign head_entry = head_bits;
    assign inst_pc    = head_entry.pc;
    assign inst       = head_entry.inst;

    no_overflow_a : assert property (@(posedge clk) disable iff (rst)
        !(take_rsp && (fifo_count == DEPTH_LIM[CW-1:0])));

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: a default-depth instance driven by a responsive memory
// model with an expected-instruction queue, plus a depth-4 instance for a scripted corner.
`timescale 1ns/1ps
module tb_if_fetch_unit;
    import if_fetch_unit_pkg::*;

    localparam logic [31:0] RST_PC = 32'h1C00_0000;
    localparam logic [31:0] MAGIC  = 32'hA5A5_A5A5;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst_pc;
    logic [31:0] inst;
    logic        inst_ready;

    logic        d4_redirect_valid;
    logic [31:0] d4_redirect_pc;
    logic        d4_imem_req;
    logic [31:0] d4_imem_addr;
    logic        d4_imem_gnt;
    logic        d4_imem_rvalid;
    logic [31:0] d4_imem_rdata;
    logic        d4_inst_valid;
    logic [31:0] d4_inst_pc;
    logic [31:0] d4_inst;
    logic        d4_inst_ready;

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } pend_t;

    pend_t       pend_q[$];
    logic [63:0] exp_q[$];
    logic [31:0] hs_q[$];
    logic [31:0] exp_fetch;
    int          n_cmp;
    int          n_err;
    int          cyc;
    bit          gnt_en;
    bit          gnt_rand;
    bit          ready_rand;
    bit          ready_val;
    int          lat_min;
    int          lat_max;

    if_fetch_unit u_dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .inst_valid     (inst_valid),
        .inst_pc        (inst_pc),
        .inst           (inst),
        .inst_ready     (inst_ready)
    );

    if_fetch_unit #(
        .BUF_DEPTH (4)
    ) u_dut4 (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (d4_redirect_valid),
        .redirect_pc    (d4_redirect_pc),
        .imem_req       (d4_imem_req),
        .imem_addr      (d4_imem_addr),
        .imem_gnt       (d4_imem_gnt),
        .imem_rvalid    (d4_imem_rvalid),
        .imem_rdata     (d4_imem_rdata),
        .inst_valid     (d4_inst_valid),
        .inst_pc        (d4_inst_pc),
        .inst           (d4_inst),
        .inst_ready     (d4_inst_ready)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic idle_inputs();
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        inst_ready     = 1'b0;
    endtask

    task automatic d4_idle();
        d4_imem_gnt       = 1'b0;
        d4_imem_rvalid    = 1'b0;
        d4_imem_rdata     = '0;
        d4_redirect_valid = 1'b0;
        d4_redirect_pc    = '0;
        d4_inst_ready     = 1'b0;
    endtask

    task automatic do_reset(input bit chk);
        rst = 1'b1;
        idle_inputs();
        d4_idle();
        pend_q.delete();
        exp_q.delete();
        hs_q.delete();
        exp_fetch = RST_PC;
        #1;
        repeat (3) begin
            @(negedge clk);
            if (chk) begin
                check("rst_req", 32'(imem_req), 32'd0);
                check("rst_addr", imem_addr, RST_PC);
                check("rst_inst_valid", 32'(inst_valid), 32'd0);
                check("rst_inst_pc", inst_pc, 32'd0);
                check("rst_inst", inst, 32'd0);
            end
        end
        rst = 1'b0;
        #1;
        if (chk) begin
            check("release_req", 32'(imem_req), 32'd1);
            check("release_addr", imem_addr, RST_PC);
        end
    endtask

    // One cycle of the memory/decode model against the default-depth instance.
    task automatic step(input bit redir, input logic [31:0] rpc);
        pend_t       p;
        logic [63:0] e;
        bit          rdy;
        bit          hs;
        if (imem_req) check("fetch_addr", imem_addr, exp_fetch);
        rdy = ready_rand ? ($urandom_range(0, 1) == 1) : ready_val;
        inst_ready = rdy;
        if (inst_valid && rdy) begin
            if (exp_q.size() == 0) begin
                check("spurious_inst_valid", 32'(inst_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("inst_pc", inst_pc, e[63:32]);
                check("inst", inst, e[31:0]);
            end
        end
        redirect_valid = redir;
        redirect_pc    = rpc;
        if (redir) begin
            exp_q.delete();
            foreach (pend_q[i]) pend_q[i].stale = 1'b1;
        end
        if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
            p = pend_q.pop_front();
            imem_rvalid = 1'b1;
            imem_rdata  = p.addr ^ MAGIC;
            if (!p.stale && !redir) exp_q.push_back({p.addr, p.addr ^ MAGIC});
        end
        imem_gnt = gnt_en && (gnt_rand ? ($urandom_range(0, 1) == 1) : 1'b1);
        hs = imem_req && imem_gnt;
        if (hs) begin
            hs_q.push_back(imem_addr);
            p.addr  = exp_fetch;
            p.due   = cyc + int'($urandom_range(lat_min, lat_max));
            p.stale = redir;
            pend_q.push_back(p);
            exp_fetch = exp_fetch + 32'd4;
        end
        if (redir) exp_fetch = {rpc[31:2], 2'b00};
        @(posedge clk);
        cyc++;
        #1;
        idle_inputs();
        @(negedge clk);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        gnt_en     = 1'b0;
        ready_rand = 1'b0;
        ready_val  = 1'b1;
        while ((pend_q.size() != 0 || exp_q.size() != 0) && n < 64) begin
            step(1'b0, 32'd0);
            n++;
        end
        check({tag, "_drained"}, 32'(exp_q.size() + pend_q.size()), 32'd0);
        check({tag, "_idle_valid"}, 32'(inst_valid), 32'd0);
    endtask

    task automatic d4_cycle(input bit g, input bit rv, input logic [31:0] rd,
                            input bit rdy, input bit redir, input logic [31:0] rpc);
        d4_imem_gnt       = g;
        d4_imem_rvalid    = rv;
        d4_imem_rdata     = rd;
        d4_inst_ready     = rdy;
        d4_redirect_valid = redir;
        d4_redirect_pc    = rpc;
        @(posedge clk);
        cyc++;
        #1;
        d4_idle();
        @(negedge clk);
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        cyc        = 0;
        gnt_en     = 1'b0;
        gnt_rand   = 1'b0;
        ready_rand = 1'b0;
        ready_val  = 1'b0;
        lat_min    = 1;
        lat_max    = 1;

        // Reset values and first request
        do_reset(1'b1);

        // Streaming
        gnt_en = 1'b1; lat_min = 1; lat_max = 1; ready_val = 1'b1;
        step(1'b0, 32'd0);
        step(1'b0, 32'd0);
        check("stream_first_valid", 32'(inst_valid), 32'd1);
        check("stream_first_pc", inst_pc, 32'h1C00_0000);
        check("stream_first_inst", inst, 32'h1C00_0000 ^ MAGIC);
        step(1'b0, 32'd0);
        check("stream_second_pc", inst_pc, 32'h1C00_0004);
        check("stream_second_inst", inst, 32'h1C00_0004 ^ MAGIC);
        repeat (20) step(1'b0, 32'd0);
        drain("stream");

        // Backpressure
        do_reset(1'b0);
        gnt_en = 1'b1; lat_min = 1; lat_max = 1; ready_val = 1'b0;
        repeat (6) step(1'b0, 32'd0);
        check("bp_valid", 32'(inst_valid), 32'd1);
        check("bp_req_low", 32'(imem_req), 32'd0);
        check("bp_grants", 32'(hs_q.size()), 32'd2);
        ready_val = 1'b1;
        step(1'b0, 32'd0);
        check("bp_req_resume", 32'(imem_req), 32'd1);
        drain("bp");

        // Redirect with two requests in flight
        do_reset(1'b0);
        gnt_en = 1'b1; lat_min = 3; lat_max = 3; ready_val = 1'b1;
        step(1'b0, 32'd0);
        step(1'b0, 32'd0);
        check("redir_inflight", 32'(hs_q.size()), 32'd2);
        step(1'b1, 32'h1C00_0102);
        check("redir_addr", imem_addr, 32'h1C00_0100);
        check("redir_valid_low", 32'(inst_valid), 32'd0);
        repeat (12) step(1'b0, 32'd0);
        drain("redir");

        // Redirect coincident with grant, response and pop (depth-4 instance)
        do_reset(1'b0);
        d4_cycle(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
        d4_cycle(1'b1, 1'b1, 32'h1C00_0000 ^ MAGIC, 1'b1, 1'b0, 32'd0);
        d4_cycle(1'b1, 1'b1, 32'h1C00_0004 ^ MAGIC, 1'b0, 1'b0, 32'd0);
        check("sim_head_valid", 32'(d4_inst_valid), 32'd1);
        check("sim_head_pc", d4_inst_pc, 32'h1C00_0000);
        check("sim_req", 32'(d4_imem_req), 32'd1);
        check("sim_addr", d4_imem_addr, 32'h1C00_000C);
        d4_cycle(1'b1, 1'b1, 32'h1C00_0008 ^ MAGIC, 1'b1, 1'b1, 32'h1C00_0200);
        check("sim_flush_valid", 32'(d4_inst_valid), 32'd0);
        check("sim_target_addr", d4_imem_addr, 32'h1C00_0200);
        check("sim_target_req", 32'(d4_imem_req), 32'd1);
        d4_cycle(1'b1, 1'b1, 32'h1C00_000C ^ MAGIC, 1'b1, 1'b0, 32'd0);
        check("sim_granted_dropped", 32'(d4_inst_valid), 32'd0);
        d4_cycle(1'b0, 1'b1, 32'h1C00_0200 ^ MAGIC, 1'b1, 1'b0, 32'd0);
        check("sim_target_valid", 32'(d4_inst_valid), 32'd1);
        check("sim_target_pc", d4_inst_pc, 32'h1C00_0200);
        check("sim_target_inst", d4_inst, 32'h1C00_0200 ^ MAGIC);
        d4_cycle(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
        check("sim_empty", 32'(d4_inst_valid), 32'd0);

        // Address wrap, then asynchronous reset mid-cycle
        do_reset(1'b0);
        gnt_en = 1'b1; lat_min = 1; lat_max = 1; ready_val = 1'b0;
        step(1'b1, 32'hFFFF_FFFC);
        repeat (4) step(1'b0, 32'd0);
        check("wrap_grants", 32'(hs_q.size()), 32'd3);
        if (hs_q.size() >= 3) begin
            check("wrap_first_addr", hs_q[1], 32'hFFFF_FFFC);
            check("wrap_second_addr", hs_q[2], 32'h0000_0000);
        end
        check("wrap_head_valid", 32'(inst_valid), 32'd1);
        check("wrap_head_pc", inst_pc, 32'hFFFF_FFFC);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("areset_req", 32'(imem_req), 32'd0);
        check("areset_addr", imem_addr, RST_PC);
        check("areset_valid", 32'(inst_valid), 32'd0);
        check("areset_pc", inst_pc, 32'd0);
        check("areset_inst", inst, 32'd0);
        @(negedge clk);
        do_reset(1'b0);
        gnt_en = 1'b1; ready_val = 1'b1;
        repeat (8) step(1'b0, 32'd0);
        drain("post_reset");

        // Random grants, latencies, backpressure and redirects
        do_reset(1'b0);
        gnt_en = 1'b1; gnt_rand = 1'b1; ready_rand = 1'b1; lat_min = 1; lat_max = 3;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 15) == 0) step(1'b1, $urandom);
            else step(1'b0, 32'd0);
        end
        gnt_rand = 1'b0;
        drain("random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
